// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the RAM-side mv/moc handshake.
// slave = arbiter side, master = requesters plus RAM model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              req0, req1;
  logic              rw0, rw1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        type0, type1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_mv;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_type;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_moc;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, type0, type1, wdata0, wdata1,
    output ack0, ack1, err, rdata,
    output mem_mv, mem_rw, mem_addr, mem_type, mem_din,
    input  mem_dout, mem_moc
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, type0, type1, wdata0, wdata1,
    input  ack0, ack1, err, rdata,
    input  mem_mv, mem_rw, mem_addr, mem_type, mem_din,
    output mem_dout, mem_moc
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-port arbiter sequencing one RAM access at a time over the
// mv/moc handshake, with alignment check, timeout and size zero-extension.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              mv;
    logic              rw;
    logic [1:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } mem_t;

  typedef struct packed {
    logic [1:0]        ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  state_t          state, nxt;
  logic [1:0]      req;
  req_t [1:0]      rq;
  logic            gsel, port, port_d, last_grant, last_d;
  logic [CW-1:0]   cnt, cnt_d;
  mem_t            mem, mem_d;
  rsp_t            rsp, rsp_d;

  assign req   = {bus.req1, bus.req0};
  assign rq[0] = '{rw: bus.rw0, typ: bus.type0, addr: bus.addr0, wdata: bus.wdata0};
  assign rq[1] = '{rw: bus.rw1, typ: bus.type1, addr: bus.addr1, wdata: bus.wdata1};

  function automatic logic misaligned(input logic [1:0] t, input logic [2:0] a);
    case (t)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      2'b11:   misaligned = |a[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] zext(input logic [1:0] t, input logic [DATA_W-1:0] d);
    case (t)
      2'b00:   zext = DATA_W'(d[7:0]);
      2'b01:   zext = DATA_W'(d[15:0]);
      2'b10:   zext = DATA_W'(d[31:0]);
      default: zext = d;
    endcase
  endfunction

  always_comb begin
    nxt       = state;
    port_d    = port;
    last_d    = last_grant;
    cnt_d     = cnt;
    mem_d     = mem;
    rsp_d     = rsp;
    rsp_d.ack = '0;
    gsel      = (req == 2'b11) ? ~last_grant : req[1];
    case (state)
      IDLE: begin
        // A still-asserted moc belongs to the previous access; hold off.
        if (!bus.mem_moc && (|req)) begin
          port_d = gsel;
          if (misaligned(rq[gsel].typ, rq[gsel].addr[2:0])) begin
            nxt            = RESP;
            rsp_d.err      = 1'b1;
            rsp_d.rdata    = '0;
            rsp_d.ack[gsel] = 1'b1;
          end else begin
            // RAM registers load here so they are already valid in ISSUE.
            nxt   = ISSUE;
            mem_d = '{mv: 1'b1, rw: rq[gsel].rw, typ: rq[gsel].typ,
                      addr: rq[gsel].addr, din: rq[gsel].wdata};
            cnt_d = '0;
          end
        end
      end
      ISSUE: nxt = WAIT;
      WAIT: begin
        if (bus.mem_moc) begin
          nxt             = RESP;
          mem_d.mv        = 1'b0;
          rsp_d.err       = 1'b0;
          rsp_d.rdata     = mem.rw ? zext(mem.typ, bus.mem_dout) : '0;
          rsp_d.ack[port] = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          nxt             = RESP;
          mem_d.mv        = 1'b0;
          rsp_d.err       = 1'b1;
          rsp_d.rdata     = '0;
          rsp_d.ack[port] = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        last_d = port;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      port       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem        <= '0;
      rsp        <= '0;
    end else begin
      state      <= nxt;
      port       <= port_d;
      last_grant <= last_d;
      cnt        <= cnt_d;
      mem        <= mem_d;
      rsp        <= rsp_d;
    end
  end

  assign bus.mem_mv   = mem.mv;
  assign bus.mem_rw   = mem.rw;
  assign bus.mem_type = mem.typ;
  assign bus.mem_addr = mem.addr;
  assign bus.mem_din  = mem.din;
  assign bus.ack0     = rsp.ack[0];
  assign bus.ack1     = rsp.ack[1];
  assign bus.err      = rsp.err;
  assign bus.rdata    = rsp.rdata;

  a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(rsp.ack[0] && rsp.ack[1]));
  a_wait_mv: assert property (@(posedge clk) disable iff (!rst_n) (state == WAIT) |-> mem.mv);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RAM handshake is driven by hand per scenario.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(64)) bus ();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(8), .DATA_W(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.mem_mv !== 1'b0) begin errors++; $display("FAIL reset_mv got %0b want 0", bus.mem_mv); end
    checks++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {bus.ack0, bus.ack1}); end
    checks++;
    if (bus.err !== 1'b0 || bus.rdata !== 64'h0) begin
      errors++; $display("FAIL reset_rsp got err=%0b rdata=%h want 0/0", bus.err, bus.rdata);
    end
    checks++;
    if ({bus.mem_rw, bus.mem_type, bus.mem_addr, bus.mem_din} !== 75'h0) begin
      errors++; $display("FAIL reset_mem got rw=%0b type=%0d addr=%h din=%h want all 0",
                         bus.mem_rw, bus.mem_type, bus.mem_addr, bus.mem_din);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_byte();
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h10; bus.type0 = 2'b00;
    step();
    checks++;
    if ({bus.mem_mv, bus.mem_rw, bus.mem_addr} !== {1'b1, 1'b1, 8'h10}) begin
      errors++; $display("FAIL read_issue got mv=%0b rw=%0b addr=%h want 1/1/10", bus.mem_mv, bus.mem_rw, bus.mem_addr);
    end
    step();
    checks++;
    if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL read_early_ack got %0b want 0", bus.ack0); end
    bus.mem_moc = 1'b1; bus.mem_dout = 64'hDEADBEEFCAFE12A5;
    step();
    checks++;
    if ({bus.ack0, bus.ack1, bus.err, bus.mem_mv} !== 4'b1000) begin
      errors++; $display("FAIL read_ack got ack0=%0b ack1=%0b err=%0b mv=%0b want 1/0/0/0",
                         bus.ack0, bus.ack1, bus.err, bus.mem_mv);
    end
    checks++;
    if (bus.rdata !== 64'h00000000000000A5) begin errors++; $display("FAIL read_rdata got %h want a5", bus.rdata); end
    bus.req0 = 1'b0; bus.mem_moc = 1'b0;
    step();
    checks++;
    if (bus.ack0 !== 1'b0 || bus.rdata !== 64'hA5) begin
      errors++; $display("FAIL read_hold got ack0=%0b rdata=%h want 0/a5", bus.ack0, bus.rdata);
    end
  endtask

  task automatic test_write_dword();
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 8'h08; bus.type1 = 2'b11;
    bus.wdata1 = 64'h0123456789ABCDEF;
    step();
    // Requester lets go and scribbles on its inputs; the access must carry on.
    bus.req1 = 1'b0; bus.wdata1 = 64'hFFFF_FFFF_FFFF_FFFF; bus.addr1 = 8'hFF;
    step();
    checks++;
    if ({bus.mem_mv, bus.mem_rw, bus.mem_type, bus.mem_addr} !== {1'b1, 1'b0, 2'b11, 8'h08}) begin
      errors++; $display("FAIL write_ctrl got mv=%0b rw=%0b type=%0d addr=%h want 1/0/3/08",
                         bus.mem_mv, bus.mem_rw, bus.mem_type, bus.mem_addr);
    end
    checks++;
    if (bus.mem_din !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL write_din got %h want 0123456789abcdef", bus.mem_din); end
    bus.mem_moc = 1'b1; bus.mem_dout = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    checks++;
    if ({bus.ack1, bus.ack0, bus.err} !== 3'b100 || bus.rdata !== 64'h0) begin
      errors++; $display("FAIL write_ack got ack1=%0b ack0=%0b err=%0b rdata=%h want 1/0/0/0",
                         bus.ack1, bus.ack0, bus.err, bus.rdata);
    end
    bus.mem_moc = 1'b0;
    step();
    checks++;
    if (bus.ack1 !== 1'b0 || bus.mem_mv !== 1'b0) begin
      errors++; $display("FAIL write_done got ack1=%0b mv=%0b want 0/0", bus.ack1, bus.mem_mv);
    end
  endtask

  task automatic test_misaligned();
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h02; bus.type0 = 2'b10;
    step();
    checks++;
    if ({bus.ack0, bus.err, bus.mem_mv} !== 3'b110) begin
      errors++; $display("FAIL misalign_word got ack0=%0b err=%0b mv=%0b want 1/1/0", bus.ack0, bus.err, bus.mem_mv);
    end
    bus.req0 = 1'b0;
    step();
    checks++;
    if ({bus.ack0, bus.err, bus.mem_mv} !== 3'b010) begin
      errors++; $display("FAIL misalign_hold got ack0=%0b err=%0b mv=%0b want 0/1/0", bus.ack0, bus.err, bus.mem_mv);
    end
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 8'h04; bus.type1 = 2'b11;
    step();
    checks++;
    if ({bus.ack1, bus.err, bus.mem_mv} !== 3'b110) begin
      errors++; $display("FAIL misalign_dword got ack1=%0b err=%0b mv=%0b want 1/1/0", bus.ack1, bus.err, bus.mem_mv);
    end
    bus.req1 = 1'b0;
    step();
  endtask

  task automatic test_moc_stuck();
    logic seen = 1'b0;
    bus.mem_moc = 1'b1;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 8'h33; bus.type1 = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.mem_mv || bus.ack0 || bus.ack1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL moc_stuck_grant got activity=1 want 0"); end
    bus.mem_moc = 1'b0;
    step();
    checks++;
    if (bus.mem_mv !== 1'b1 || bus.mem_addr !== 8'h33) begin
      errors++; $display("FAIL moc_release got mv=%0b addr=%h want 1/33", bus.mem_mv, bus.mem_addr);
    end
    step();
    bus.mem_moc = 1'b1; bus.mem_dout = 64'h1111_2222_3333_4477;
    step();
    checks++;
    if ({bus.ack1, bus.err} !== 2'b10 || bus.rdata !== 64'h77) begin
      errors++; $display("FAIL moc_read got ack1=%0b err=%0b rdata=%h want 1/0/77", bus.ack1, bus.err, bus.rdata);
    end
    bus.mem_moc = 1'b0; bus.req1 = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    int mvc = 0;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h30; bus.type0 = 2'b10;
    bus.mem_moc = 1'b0; bus.mem_dout = 64'hABCD_ABCD_ABCD_ABCD;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (bus.mem_mv === 1'b1) mvc++;
      if (bus.ack0 === 1'b1) break;
    end
    bus.req0 = 1'b0;
    checks++;
    if (bus.ack0 !== 1'b1) begin errors++; $display("FAIL timeout_ack got ack0=%0b after %0d cycles want 1", bus.ack0, n); end
    checks++;
    if (n != TIMEOUT + 2) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, TIMEOUT + 2); end
    checks++;
    if (mvc != TIMEOUT + 1) begin errors++; $display("FAIL timeout_mv_cycles got %0d want %0d", mvc, TIMEOUT + 1); end
    checks++;
    if (bus.err !== 1'b1 || bus.rdata !== 64'h0) begin
      errors++; $display("FAIL timeout_rsp got err=%0b rdata=%h want 1/0", bus.err, bus.rdata);
    end
    step();
    checks++;
    if (bus.ack0 !== 1'b0 || bus.mem_mv !== 1'b0) begin
      errors++; $display("FAIL timeout_done got ack0=%0b mv=%0b want 0/0", bus.ack0, bus.mem_mv);
    end
  endtask

  task automatic test_reset_mid();
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h12; bus.type0 = 2'b01;
    step();
    step();
    checks++;
    if (bus.mem_mv !== 1'b1) begin errors++; $display("FAIL rstmid_wait got mv=%0b want 1", bus.mem_mv); end
    rst_n = 1'b0;
    step();
    checks++;
    if ({bus.mem_mv, bus.ack0, bus.ack1} !== 3'b000) begin
      errors++; $display("FAIL rstmid_abort got mv=%0b ack0=%0b ack1=%0b want 0/0/0", bus.mem_mv, bus.ack0, bus.ack1);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.mem_mv, bus.mem_type, bus.mem_addr} !== {1'b1, 2'b01, 8'h12}) begin
      errors++; $display("FAIL rstmid_regrant got mv=%0b type=%0d addr=%h want 1/1/12", bus.mem_mv, bus.mem_type, bus.mem_addr);
    end
    step();
    bus.mem_moc = 1'b1; bus.mem_dout = 64'h5555_6666_1234_BEEF;
    step();
    checks++;
    if ({bus.ack0, bus.err} !== 2'b10 || bus.rdata !== 64'hBEEF) begin
      errors++; $display("FAIL rstmid_read got ack0=%0b err=%0b rdata=%h want 1/0/beef", bus.ack0, bus.err, bus.rdata);
    end
    bus.mem_moc = 1'b0; bus.req0 = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [7:0] want_addr;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 8'h20; bus.type0 = 2'b10;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 8'h40; bus.type1 = 2'b10;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int w = 0;
      while (bus.mem_mv !== 1'b1 && w < 10) begin
        step();
        w++;
      end
      want_addr = (i % 2 == 0) ? 8'h20 : 8'h40;
      checks++;
      if (bus.mem_mv !== 1'b1 || bus.mem_addr !== want_addr) begin
        errors++; $display("FAIL rr_grant%0d got mv=%0b addr=%h want 1/%h", i, bus.mem_mv, bus.mem_addr, want_addr);
      end
      step();
      bus.mem_moc = 1'b1; bus.mem_dout = 64'hFFEEDDCC11223344;
      step();
      checks++;
      if (bus.ack0 !== (i % 2 == 0) || bus.ack1 !== (i % 2 == 1) || bus.rdata !== 64'h11223344) begin
        errors++; $display("FAIL rr_ack%0d got ack0=%0b ack1=%0b rdata=%h want %0b/%0b/11223344",
                           i, bus.ack0, bus.ack1, bus.rdata, (i % 2 == 0), (i % 2 == 1));
      end
      bus.mem_moc = 1'b0;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    step();
  endtask

  initial begin
    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = '0; bus.type0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = '0; bus.type1 = '0; bus.wdata1 = '0;
    bus.mem_dout = '0; bus.mem_moc = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_read_byte();
    test_write_dword();
    test_misaligned();
    test_moc_stuck();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
